// File: rtl/std_fp_div_iter.sv
// Iterative restoring fixed-point divider: left/right in Q(INT_WIDTH).(FRAC_WIDTH),
// one quotient bit per cycle, with a go/done handshake matching the pipelined multiplier.
module std_fp_div_iter #(
    parameter int WIDTH      = 8,
    parameter int INT_WIDTH  = 4,
    parameter int FRAC_WIDTH = 4,
    parameter int SIGNED     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             done
);

    localparam int N  = WIDTH + FRAC_WIDTH;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] N_CNT = CW'(N);

    if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_bad_width
        $error("std_fp_div_iter: WIDTH must equal INT_WIDTH + FRAC_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [N-1:0]     dq;        // dividend shifts out the top while quotient bits shift in at the bottom
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] left_q;
    logic             sign_l, sign_r, div_zero;

    logic             left_neg, right_neg;
    logic [WIDTH-1:0] left_mag, right_mag;
    logic [WIDTH:0]   rem_shift, rem_step;
    logic             fits;
    logic [WIDTH-1:0] q_mag, r_mag, q_res, r_res;

    // Magnitudes are unsigned WIDTH-bit values, so the most-negative input maps to 2^(WIDTH-1).
    always_comb begin
        left_neg  = (SIGNED != 0) && left[WIDTH-1];
        right_neg = (SIGNED != 0) && right[WIDTH-1];
        left_mag  = left_neg  ? -left  : left;
        right_mag = right_neg ? -right : right;
    end

    always_comb begin
        rem_shift = {rem[WIDTH-1:0], dq[N-1]};
        fits      = rem_shift >= {1'b0, divisor};
        rem_step  = fits ? rem_shift - {1'b0, divisor} : rem_shift;
    end

    always_comb begin
        q_mag = dq[WIDTH-1:0];
        r_mag = rem[WIDTH-1:0];
        if (div_zero) begin
            q_res = '1;
            r_res = left_q;
        end else begin
            q_res = (sign_l ^ sign_r) ? -q_mag : q_mag;
            r_res = sign_l ? -r_mag : r_mag;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (go) state_next = BUSY;
            BUSY: begin
                if (!go)                     state_next = IDLE;
                else if (count == CW'(1))    state_next = FIX;
            end
            FIX:     state_next = go ? DONE : IDLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: datapath registers are not reset; they are always loaded in IDLE before being used.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (go) begin
                    dq       <= {left_mag, {FRAC_WIDTH{1'b0}}};
                    rem      <= '0;
                    divisor  <= right_mag;
                    left_q   <= left;
                    sign_l   <= left_neg;
                    sign_r   <= right_neg;
                    div_zero <= (right == '0);
                    count    <= N_CNT;
                end
            end
            BUSY: begin
                dq    <= {dq[N-2:0], fits};
                rem   <= rem_step;
                count <= count - CW'(1);
            end
            default: ;
        endcase
    end

    // Results only move on a completed FIX, so aborted operations leave the last result visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_quotient  <= '0;
            out_remainder <= '0;
        end else if (state == FIX && go) begin
            out_quotient  <= q_res;
            out_remainder <= r_res;
        end
    end

    assign done = (state == DONE);

endmodule

// File: tb/tb_std_fp_div_iter.sv
// Directed self-checking bench for std_fp_div_iter (8/4/4 signed): vector table plus
// hand-written abort, reset and back-to-back sequences.
module tb_std_fp_div_iter;

    logic       clk = 1'b0;
    logic       reset;
    logic       go;
    logic [7:0] left, right;
    logic [7:0] out_quotient, out_remainder;
    logic       done;

    int checks   = 0;
    int failures = 0;

    std_fp_div_iter #(.WIDTH(8), .INT_WIDTH(4), .FRAC_WIDTH(4), .SIGNED(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .left          (left),
        .right         (right),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] l;
        logic [7:0] r;
        logic [7:0] exp_q;
        logic [7:0] exp_r;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; that cycle is cycle 0. Returns the cycle in which
    // done was seen (-1 on timeout) and whether done was high in the following cycle.
    task automatic run_op(input logic [7:0] l, input logic [7:0] r,
                          output int done_cyc, output logic done_after);
        go = 1'b1;
        left = l;
        right = r;
        done_cyc = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        go = 1'b0;
        @(negedge clk);
        done_after = done;
        @(posedge clk); #1;
    endtask

    vec_t vecs[10];
    int   dc, gap;
    logic da, seen, stable;

    initial begin
        vecs[0] = '{8'h60, 8'h20, 8'h30, 8'h00};  //  6.0 / 2.0
        vecs[1] = '{8'h10, 8'h30, 8'h05, 8'h10};  //  1.0 / 3.0 truncated
        vecs[2] = '{8'hA0, 8'h20, 8'hD0, 8'h00};  // -6.0 / 2.0
        vecs[3] = '{8'hE8, 8'hE0, 8'h0C, 8'h00};  // -1.5 / -2.0
        vecs[4] = '{8'h10, 8'h00, 8'hFF, 8'h10};  // divide by zero
        vecs[5] = '{8'h70, 8'h01, 8'h00, 8'h00};  // overflow wraps
        vecs[6] = '{8'h80, 8'h10, 8'h80, 8'h00};  // most-negative dividend
        vecs[7] = '{8'h18, 8'hF0, 8'hE8, 8'h00};  //  1.5 / -1.0
        vecs[8] = '{8'h90, 8'h00, 8'hFF, 8'h90};  // divide by zero, negative left
        vecs[9] = '{8'hF0, 8'h30, 8'hFB, 8'hF0};  // -1.0 / 3.0, negative remainder

        reset = 1'b1;
        go = 1'b0;
        left = '0;
        right = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_q", out_quotient, 8'h00);
        check("reset_r", out_remainder, 8'h00);
        check("reset_done", done, 1'b0);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].l, vecs[i].r, dc, da);
            check($sformatf("v%0d_done_cycle", i), dc, 14);
            check($sformatf("v%0d_q", i), out_quotient, vecs[i].exp_q);
            check($sformatf("v%0d_r", i), out_remainder, vecs[i].exp_r);
            check($sformatf("v%0d_done_after", i), da, 1'b0);
        end

        // Abort: go dropped in cycle 5.
        go = 1'b1; left = 8'h60; right = 8'h20;
        repeat (5) begin @(posedge clk); #1; end
        go = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort_no_done", seen, 1'b0);
        check("abort_hold_q", out_quotient, 8'hFB);
        check("abort_hold_r", out_remainder, 8'hF0);
        @(posedge clk); #1;

        // Reset asserted in cycle 7 of an operation.
        go = 1'b1; left = 8'h60; right = 8'h20;
        repeat (7) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        go = 1'b0;
        @(negedge clk);
        check("midreset_q", out_quotient, 8'h00);
        check("midreset_r", out_remainder, 8'h00);
        check("midreset_done", done, 1'b0);
        @(posedge clk); #1;
        run_op(8'h10, 8'h30, dc, da);
        check("post_reset_done_cycle", dc, 14);
        check("post_reset_q", out_quotient, 8'h05);
        check("post_reset_r", out_remainder, 8'h10);

        // Back-to-back: go held through done, new operands presented in the DONE cycle.
        go = 1'b1; left = 8'h60; right = 8'h20;
        dc = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) begin
                dc = c;
                break;
            end
            @(posedge clk); #1;
        end
        check("b2b_first_done_cycle", dc, 14);
        check("b2b_first_q", out_quotient, 8'h30);
        left = 8'hE8;
        right = 8'hE0;
        gap = -1;
        stable = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                gap = k;
                break;
            end
            if (out_quotient !== 8'h30 || out_remainder !== 8'h00) stable = 1'b0;
        end
        check("b2b_gap", gap, 15);
        check("b2b_first_stable", stable, 1'b1);
        check("b2b_second_q", out_quotient, 8'h0C);
        check("b2b_second_r", out_remainder, 8'h00);
        @(posedge clk); #1;
        go = 1'b0;
        @(negedge clk);
        check("b2b_done_single", done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
